// File: rtl/vie_rf_wport_arb_pkg.sv
// rtl/vie_rf_wport_arb_pkg.sv - shared widths, defaults, FSM encoding and md entry type
package vie_rf_wport_arb_pkg;
  localparam int VIE_AW         = 5;
  localparam int VIE_DW         = 32;
  localparam int VIE_PCW        = 32;
  localparam int VIE_STARVE_MAX = 4;
  localparam int VIE_MD_DEPTH   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [VIE_AW-1:0]  waddr;
    logic [VIE_DW-1:0]  wdata;
    logic [VIE_PCW-1:0] pc;
  } md_entry_t;
endpackage

// File: rtl/vie_md_fifo.sv
// rtl/vie_md_fifo.sv - md result buffer: storage, wrap pointers, count and pending-register mask
module vie_md_fifo
  import vie_rf_wport_arb_pkg::*;
#(
  parameter  int DEPTH = VIE_MD_DEPTH,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  md_entry_t              push_entry,
  input  logic                   pop,
  output md_entry_t              head,
  output logic [CW-1:0]          count,
  output logic                   full,
  output logic                   empty,
  output logic [2**VIE_AW-1:0]   pend_mask
);
  md_entry_t       mem_q [DEPTH];
  md_entry_t       mem_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = ptr_inc(rd_ptr_q);
    end
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Payload storage is deliberately left out of reset; the valid bits gate it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) pend_mask[mem_q[i].waddr] = 1'b1;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = cnt_q;
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
endmodule

// File: rtl/vie_rf_wport_arb.sv
// rtl/vie_rf_wport_arb.sv - single regfile write port shared by WB stage and multi-cycle unit
module vie_rf_wport_arb
  import vie_rf_wport_arb_pkg::*;
#(
  parameter int STARVE_MAX = VIE_STARVE_MAX,
  parameter int DEPTH      = VIE_MD_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ws_we,
  input  logic [VIE_AW-1:0]   ws_waddr,
  input  logic [VIE_DW-1:0]   ws_wdata,
  input  logic [VIE_PCW-1:0]  ws_pc,
  input  logic                md_valid,
  input  logic [VIE_AW-1:0]   md_waddr,
  input  logic [VIE_DW-1:0]   md_wdata,
  input  logic [VIE_PCW-1:0]  md_pc,
  output logic                md_ready,
  output logic                rf_we,
  output logic [VIE_AW-1:0]   rf_waddr,
  output logic [VIE_DW-1:0]   rf_wdata,
  output logic [VIE_PCW-1:0]  debug_wb_pc,
  output logic [3:0]          debug_wb_rf_wen,
  output logic [VIE_AW-1:0]   debug_wb_rf_wnum,
  output logic [VIE_DW-1:0]   debug_wb_rf_wdata,
  output logic                ws_hold,
  output logic [2**VIE_AW-1:0] pend_mask,
  output logic                proto_err
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  md_entry_t     head;
  logic [CW-1:0] count;
  logic          full, empty, push, pop, last_pop;
  arb_state_e    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          ws_hold_q, ws_hold_d, proto_err_q, proto_err_d;

  assign md_ready = !full;
  assign push     = md_valid && md_ready;
  assign pop      = !ws_we && !empty;
  assign last_pop = pop && !push && (count == CW'(1));

  vie_md_fifo #(.DEPTH(DEPTH)) u_md_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry ('{waddr: md_waddr, wdata: md_wdata, pc: md_pc}),
    .pop        (pop),
    .head       (head),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .pend_mask  (pend_mask)
  );

  always_comb begin
    rf_we       = ws_we || !empty;
    rf_waddr    = '0;
    rf_wdata    = '0;
    debug_wb_pc = '0;
    if (ws_we) begin
      rf_waddr    = ws_waddr;
      rf_wdata    = ws_wdata;
      debug_wb_pc = ws_pc;
    end else if (!empty) begin
      rf_waddr    = head.waddr;
      rf_wdata    = head.wdata;
      debug_wb_pc = head.pc;
    end
  end

  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    proto_err_d = proto_err_q || (ws_we && ws_hold_q);
    case (state_q)
      ST_IDLE: begin
        starve_d = '0;
        if (push) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (pop) begin
          starve_d = '0;
          if (last_pop) state_d = ST_IDLE;
        end else if (ws_we) begin
          if (starve_q != SW'(STARVE_MAX)) starve_d = starve_q + 1'b1;
          if (starve_d == SW'(STARVE_MAX)) state_d = ST_FORCE;
        end
      end
      ST_FORCE: begin
        // Only a pop releases the hold; a WB write here is a protocol violation.
        if (pop) begin
          starve_d = '0;
          state_d  = last_pop ? ST_IDLE : ST_PEND;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        starve_d = '0;
      end
    endcase
    ws_hold_d = (state_d == ST_FORCE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      ws_hold_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      ws_hold_q   <= ws_hold_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign ws_hold   = ws_hold_q;
  assign proto_err = proto_err_q;
endmodule

// File: tb/tb_vie_rf_wport_arb.sv
// tb/tb_vie_rf_wport_arb.sv - randomized and directed bench against a queue-based reference model
module tb_vie_rf_wport_arb;
  localparam int SMAX = 4;
  localparam int DEP  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ws_we = 1'b0, md_valid = 1'b0;
  logic [4:0]  ws_waddr = '0, md_waddr = '0;
  logic [31:0] ws_wdata = '0, ws_pc = '0, md_wdata = '0, md_pc = '0;
  logic        md_ready, rf_we, ws_hold, proto_err;
  logic [4:0]  rf_waddr, debug_wb_rf_wnum;
  logic [31:0] rf_wdata, debug_wb_pc, debug_wb_rf_wdata, pend_mask;
  logic [3:0]  debug_wb_rf_wen;

  vie_rf_wport_arb #(.STARVE_MAX(SMAX), .DEPTH(DEP)) dut (
    .clk(clk), .rst_n(rst_n),
    .ws_we(ws_we), .ws_waddr(ws_waddr), .ws_wdata(ws_wdata), .ws_pc(ws_pc),
    .md_valid(md_valid), .md_waddr(md_waddr), .md_wdata(md_wdata), .md_pc(md_pc),
    .md_ready(md_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .ws_hold(ws_hold), .pend_mask(pend_mask), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];
  int   starve;
  bit   hold_m, perr_m;

  task automatic model_reset();
    q.delete();
    starve = 0;
    hold_m = 0;
    perr_m = 0;
  endtask

  task automatic check_outputs();
    logic [31:0] pm;
    bit          we_exp;
    pm = '0;
    foreach (q[i]) pm[q[i].a] = 1'b1;
    we_exp = ws_we || (q.size() > 0);
    chk("md_ready", md_ready, 32'(q.size() < DEP));
    chk("pend_mask", pend_mask, pm);
    chk("ws_hold", ws_hold, 32'(hold_m));
    chk("proto_err", proto_err, 32'(perr_m));
    chk("rf_we", rf_we, 32'(we_exp));
    chk("dbg_wen", debug_wb_rf_wen, {28'd0, {4{we_exp}}});
    if (ws_we) begin
      chk("rf_waddr_ws", rf_waddr, ws_waddr);
      chk("rf_wdata_ws", rf_wdata, ws_wdata);
      chk("dbg_pc_ws", debug_wb_pc, ws_pc);
    end else if (q.size() > 0) begin
      chk("rf_waddr_md", rf_waddr, q[0].a);
      chk("rf_wdata_md", rf_wdata, q[0].d);
      chk("dbg_pc_md", debug_wb_pc, q[0].pc);
    end
    if (we_exp) begin
      chk("dbg_wnum", debug_wb_rf_wnum, rf_waddr);
      chk("dbg_wdata", debug_wb_rf_wdata, rf_wdata);
    end
  endtask

  // Drive one cycle of inputs and check the combinational view before the edge.
  task automatic cyc(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                     input bit mv, input logic [4:0] ma, input logic [31:0] mdat);
    ws_we = we; ws_waddr = wa; ws_wdata = wd; ws_pc = $urandom;
    md_valid = mv; md_waddr = ma; md_wdata = mdat; md_pc = $urandom;
    @(negedge clk);
    check_outputs();
  endtask

  // Apply the write-port rules to the model, then cross the clock edge.
  task automatic adv();
    bit   nonempty, pop, push;
    ent_t e;
    nonempty = q.size() > 0;
    pop      = !ws_we && nonempty;
    push     = md_valid && (q.size() < DEP);
    e        = '{md_waddr, md_wdata, md_pc};
    if (ws_we && hold_m) perr_m = 1;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(e);
    if (hold_m) begin
      if (pop) begin hold_m = 0; starve = 0; end
    end else if (pop || !nonempty) begin
      starve = 0;
    end else if (ws_we) begin
      if (starve < SMAX) starve++;
      if (starve == SMAX) hold_m = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ws_we = 0; md_valid = 0;
    rst_n = 1'b0;
    model_reset();
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic step(input bit we, input logic [4:0] wa, input bit mv, input logic [4:0] ma);
    cyc(we, wa, $urandom, mv, ma, $urandom);
    adv();
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst_md_ready", md_ready, 1);
    chk("rst_pend_mask", pend_mask, 0);
    chk("rst_ws_hold", ws_hold, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_rf_we", rf_we, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // idle md push writes on the next cycle
    cyc(0, 0, 0, 1, 5'd5, 32'h1234);
    chk("idle_ready", md_ready, 1);
    adv();
    cyc(0, 0, 0, 0, 0, 0);
    chk("idle_we", rf_we, 1);
    chk("idle_waddr", rf_waddr, 5);
    chk("idle_wdata", rf_wdata, 32'h1234);
    chk("idle_pmask", pend_mask, 32'h20);
    adv();
    cyc(0, 0, 0, 0, 0, 0);
    chk("idle_pmask_clr", pend_mask, 0);
    adv();

    // WB wins over a pending entry; the entry drains once WB goes quiet
    step(1, 5'd9, 1, 5'd7);
    cyc(1, 5'd3, 32'hAAAA, 0, 0, 0);
    chk("conf_waddr", rf_waddr, 3);
    adv();
    cyc(0, 0, 0, 0, 0, 0);
    chk("conf_drain", rf_waddr, 7);
    adv();

    // fill under continuous WB traffic, then drain in order
    step(1, 5'd1, 1, 5'd10);
    step(1, 5'd2, 1, 5'd11);
    cyc(1, 5'd4, 0, 1, 5'd12, 0);
    chk("full_ready", md_ready, 0);
    chk("full_pmask", pend_mask, 32'h0C00);
    adv();
    cyc(0, 0, 0, 0, 0, 0);
    chk("full_d0", rf_waddr, 10);
    adv();
    cyc(0, 0, 0, 0, 0, 0);
    chk("full_d1", rf_waddr, 11);
    adv();
    step(0, 0, 0, 0);

    // starvation forces a hold after STARVE_MAX blocked cycles
    step(1, 5'd1, 1, 5'd20);
    for (int i = 0; i < SMAX; i++) begin
      cyc(1, 5'd2, 0, 0, 0, 0);
      chk("starve_nohold", ws_hold, 0);
      adv();
    end
    cyc(0, 0, 0, 0, 0, 0);
    chk("starve_hold", ws_hold, 1);
    chk("starve_write", rf_waddr, 20);
    adv();
    cyc(0, 0, 0, 0, 0, 0);
    chk("starve_release", ws_hold, 0);
    adv();

    // WB writing during the hold flags an error and keeps the hold
    step(1, 5'd1, 1, 5'd21);
    for (int i = 0; i < SMAX; i++) step(1, 5'd2, 0, 0);
    cyc(1, 5'd6, 0, 0, 0, 0);
    chk("perr_hold", ws_hold, 1);
    adv();
    cyc(0, 0, 0, 0, 0, 0);
    chk("perr_set", proto_err, 1);
    chk("perr_still_hold", ws_hold, 1);
    adv();
    cyc(0, 0, 0, 0, 0, 0);
    chk("perr_released", ws_hold, 0);
    chk("perr_sticky", proto_err, 1);
    adv();

    // reset with two entries pending clears immediately
    step(1, 5'd1, 1, 5'd13);
    step(1, 5'd1, 1, 5'd14);
    ws_we = 0; md_valid = 0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mrst_pmask", pend_mask, 0);
    chk("mrst_ready", md_ready, 1);
    chk("mrst_rf_we", rf_we, 0);
    chk("mrst_perr", proto_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // randomized traffic; WB honours ws_hold except for rare violations
    for (int ph = 0; ph < 3; ph++) begin
      do_reset();
      for (int n = 0; n < 300; n++) begin
        bit we;
        we = ($urandom_range(0, 99) < (ph == 0 ? 40 : 85));
        if (hold_m && $urandom_range(0, 19) != 0) we = 0;
        step(we, 5'($urandom), $urandom_range(0, 99) < 55, 5'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vie_rf_wport_arb.md
VIE_RF_WPORT_ARB -- requirements
Module: vie_rf_wport_arb

Interface
REQ-001 Parameter STARVE_MAX, default 4: number of consecutive blocked cycles of a pending md entry before the WB stage is forced to hold.
REQ-002 Parameter DEPTH, default 2: number of md result buffer entries.
REQ-003 clock  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 ws_we, ws_waddr, ws_wdata, ws_pc  in  1/5/32/32  WB-stage regfile write request; no ready signal, always granted when asserted.
REQ-006 md_valid, md_waddr, md_wdata, md_pc  in  1/5/32/32  multi-cycle unit result request.
REQ-007 md_ready  out  1  md result accepted on a cycle where md_valid and md_ready are both high.
REQ-008 rf_we, rf_waddr, rf_wdata  out  1/5/32/32  the single regfile write port.
REQ-009 debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata  out  32/4/5/32  trace of the granted write; wen is {4{rf_we}}.
REQ-010 ws_hold  out  1  registered; the WB stage drops its can-go and presents no write while high.
REQ-011 pend_mask  out  32  bit n set while any buffered md entry targets register n; decode interlock source.
REQ-012 proto_err  out  1  sticky flag for an ws_we assertion during ws_hold.

Function
REQ-013 Port priority: ws_we=1 grants WB; else a non-empty buffer grants its head entry; else rf_we=0.
REQ-014 Writes to register 0 pass through unchanged; the regfile discards them.
REQ-015 md results enter a DEPTH-entry FIFO; md_ready = !full, purely combinational from the registered count.
REQ-016 Fixed latency: an accepted md result is writable no earlier than the following cycle; no bypass from md inputs to rf outputs.
REQ-017 Simultaneous push and pop on a full FIFO is not allowed: md_ready is 0 when full regardless of a pop that cycle.
REQ-018 Pointer wrap: read and write pointers wrap modulo DEPTH; count tracks 0..DEPTH exactly.
REQ-019 pend_mask is the OR of the one-hot waddr of all valid entries; it updates in the cycle after a push or pop.
REQ-020 FSM states: IDLE (FIFO empty), PEND (FIFO non-empty, draining opportunistically), FORCE (ws_hold=1).
REQ-021 IDLE->PEND on push; PEND->IDLE when the last entry pops with no push in the same cycle.
REQ-022 Starve counter: clears in IDLE and on every pop; increments in PEND on each cycle in which the head is blocked by ws_we; saturates at STARVE_MAX.
REQ-023 PEND->FORCE when the counter reaches STARVE_MAX; FORCE lasts exactly one cycle, then goes to PEND or IDLE depending on the remaining count.
REQ-024 In FORCE with ws_we=0, the head is written; with ws_we=1, WB still wins, proto_err is set, and FORCE persists until a pop.
REQ-025 Output rf_* and debug_* are combinational from the grant mux; debug_wb_pc is ws_pc or the head md_pc.

Reset
REQ-026 On reset asserted: FIFO empty, pointers 0, counter 0, state IDLE, ws_hold=0, proto_err=0, pend_mask=0, md_ready=1.
REQ-027 Buffered md entries are discarded on reset mid-operation; FIFO data storage is not reset.

Structure
REQ-028 The bus widths, FSM state encodings and default STARVE_MAX/DEPTH belong in the shared defines header with the existing `V*bus widths.
REQ-029 One sub-module, vie_md_fifo (storage, pointers, count, pend_mask); arbitration, FSM and counter stay in vie_rf_wport_arb.

Verification
REQ-030 Idle md: md_valid with waddr=5, wdata=0x1234, ws_we=0 -> md_ready=1; next cycle rf_we=1, waddr=5, wdata=0x1234; pend_mask bit 5 set for that cycle only.
REQ-031 Conflict: ws_we=1 with waddr=3 while the FIFO holds waddr=7 -> rf_waddr=3, and the entry writes on the first cycle with ws_we=0.
REQ-032 Full: two md pushes while ws_we=1 continuously -> md_ready=0 after the second push, count=2, no data loss after draining.
REQ-033 Starvation: ws_we=1 every cycle, one entry pending -> ws_hold=1 at the 5th cycle; with ws_we dropped, the entry writes and ws_hold returns to 0 the next cycle.
REQ-034 Protocol error: ws_we=1 during ws_hold -> proto_err=1 and stays 1 until reset; FORCE persists until a pop.
REQ-035 Reset mid-operation: reset with 2 entries pending -> pend_mask=0, md_ready=1 and rf_we=0 immediately, without waiting for a clock edge.
